// File: rtl/clock_time_core.sv
// clock_time_core
// ---------------------------------------------------------------------------
// BCD time-of-day engine for the digital clock. Keeps hours, minutes and
// seconds as BCD nibble pairs, runs a button-driven set mode, and produces
// the digit word, decimal points, blink enables, blink clock and scan-start
// strobe consumed by the seven-segment serial display device.
//
// Parameters
//   CLK_HZ    board clock frequency (even, >= 4); half second = CLK_HZ/2
//
// Ports
//   clk       board clock, rising edge
//   rst       synchronous active-high reset
//   btn_mode  mode button level (debounced upstream)
//   btn_inc   increment button level (debounced upstream)
//   Hexs      {8'h00, hour BCD, minute BCD, second BCD}
//   point     decimal points, 1 = lit
//   LES       per-digit blink enables, 1 = blink
//   flash     blink clock for the display device
//   Start     one-cycle display scan-start strobe
//
// Configuration macro
//   CLOCK_12H_EN  when defined, the hour field is shown in 12-hour BCD and
//                 point[0] marks PM; internal hour stays 0..23.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module clock_time_core #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_mode,
   input  logic        btn_inc,
   output logic [31:0] Hexs,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic        flash,
   output logic        Start
);

   localparam int HALF = CLK_HZ / 2;
   localparam int PW   = $clog2(HALF);
   localparam logic [PW-1:0] HALF_MAX = PW'(HALF - 1);

   typedef enum logic [1:0] {
      RUN,
      SET_HOUR,
      SET_MIN,
      SET_SEC
   } state_t;

   state_t        state;
   logic [7:0]    hour_bcd;
   logic [7:0]    min_bcd;
   logic [7:0]    sec_bcd;
   logic [7:0]    les_r;

   logic          mode_q;
   logic          mode_prev;
   logic          inc_q;
   logic          inc_prev;
   logic          mode_evt;
   logic          inc_evt;

   logic [PW-1:0] presc;
   logic [PW-1:0] blink_cnt;
   logic          phase;
   logic          half_tick;
   logic          blink_tick;
   logic          sec_tick;

   logic [7:0]    hour_disp;
   logic          pm;
   logic [47:0]   disp_now;
   logic [47:0]   disp_prev;
   logic          rst_seen;
   logic          start_r;

   // Step a BCD field by one, wrapping 59 -> 00.
   function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
      if (v == 8'h59)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Step a BCD hour by one, wrapping 23 -> 00.
   function automatic logic [7:0] bcd_inc23(input logic [7:0] v);
      if (v == 8'h23)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // The level is registered once and then compared with a second copy, so a
   // press takes effect one edge after the new level has been sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 1'b0;
         mode_prev <= 1'b0;
         inc_q     <= 1'b0;
         inc_prev  <= 1'b0;
      end else begin
         mode_q    <= btn_mode;
         mode_prev <= mode_q;
         inc_q     <= btn_inc;
         inc_prev  <= inc_q;
      end
   end

   assign mode_evt = mode_q & ~mode_prev;
   assign inc_evt  = inc_q & ~inc_prev;

   assign half_tick  = (state == RUN) && (presc == HALF_MAX);
   assign blink_tick = (state != RUN) && (blink_cnt == HALF_MAX);
   assign sec_tick   = half_tick & phase;

   // The seconds prescaler only runs in RUN so that leaving set mode starts a
   // fresh second; a separate counter keeps the blink phase alive while setting.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         if (state != RUN || presc == HALF_MAX)
            presc <= '0;
         else
            presc <= presc + PW'(1);

         if (state == RUN || blink_cnt == HALF_MAX)
            blink_cnt <= '0;
         else
            blink_cnt <= blink_cnt + PW'(1);

         if (half_tick || blink_tick)
            phase <= ~phase;
      end
   end

   // Mode FSM and time registers. A second tick in RUN is applied even on the
   // edge that moves into set mode; mode presses take priority over increments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         hour_bcd <= 8'h00;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
         les_r    <= 8'h00;
      end else begin
         if (state == RUN && sec_tick) begin
            if (sec_bcd == 8'h59) begin
               sec_bcd <= 8'h00;
               if (min_bcd == 8'h59) begin
                  min_bcd  <= 8'h00;
                  hour_bcd <= bcd_inc23(hour_bcd);
               end else begin
                  min_bcd <= bcd_inc59(min_bcd);
               end
            end else begin
               sec_bcd <= bcd_inc59(sec_bcd);
            end
         end

         if (mode_evt) begin
            case (state)
               RUN: begin
                  state <= SET_HOUR;
                  les_r <= 8'h30;
               end
               SET_HOUR: begin
                  state <= SET_MIN;
                  les_r <= 8'h0C;
               end
               SET_MIN: begin
                  state <= SET_SEC;
                  les_r <= 8'h03;
               end
               default: begin
                  state <= RUN;
                  les_r <= 8'h00;
               end
            endcase
         end else if (inc_evt) begin
            case (state)
               SET_HOUR: hour_bcd <= bcd_inc23(hour_bcd);
               SET_MIN:  min_bcd  <= bcd_inc59(min_bcd);
               SET_SEC:  sec_bcd  <= bcd_inc59(sec_bcd);
               default:  ;
            endcase
         end
      end
   end

`ifdef CLOCK_12H_EN
   // 12-hour presentation of the internal 0..23 BCD hour.
   always_comb begin
      hour_disp = hour_bcd;
      case (hour_bcd)
         8'h00:   hour_disp = 8'h12;
         8'h13:   hour_disp = 8'h01;
         8'h14:   hour_disp = 8'h02;
         8'h15:   hour_disp = 8'h03;
         8'h16:   hour_disp = 8'h04;
         8'h17:   hour_disp = 8'h05;
         8'h18:   hour_disp = 8'h06;
         8'h19:   hour_disp = 8'h07;
         8'h20:   hour_disp = 8'h08;
         8'h21:   hour_disp = 8'h09;
         8'h22:   hour_disp = 8'h10;
         8'h23:   hour_disp = 8'h11;
         default: hour_disp = hour_bcd;
      endcase
   end

   // Valid BCD compares numerically, so this is simply hour >= 12.
   assign pm = (hour_bcd >= 8'h12);
`else
   assign hour_disp = hour_bcd;
   assign pm        = 1'b0;
`endif

   assign Hexs  = {8'h00, hour_disp, min_bcd, sec_bcd};
   assign point = {3'b000, phase, 1'b0, phase, 1'b0, pm};
   assign LES   = les_r;
   assign flash = phase;
   assign Start = start_r;

   assign disp_now = {Hexs, point, LES};

   // Scan-start fires the cycle after any visible display change, and once on
   // the first cycle out of reset so the display always gets an initial scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_r   <= 1'b0;
         rst_seen  <= 1'b1;
         disp_prev <= '0;
      end else begin
         start_r   <= rst_seen | (disp_now != disp_prev);
         rst_seen  <= 1'b0;
         disp_prev <= disp_now;
      end
   end

endmodule
